// File: rtl/gray_seq_monitor.sv
// Consumer of an upstream Gray-code counter: decodes each sampled word to binary,
// classifies the advance as HOLD / STEP / ILLEGAL and tracks lock, errors and wraps.
module gray_seq_monitor #(
    parameter int WIDTH    = 3,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8,
    parameter int WRAP_W   = 8
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic [WIDTH-1:0]  grayIn,
    input  logic              sampleEn,
    input  logic              clrCounts,
    output logic [WIDTH-1:0]  binOut,
    output logic              binValid,
    output logic              locked,
    output logic              errPulse,
    output logic [ERR_W-1:0]  errCount,
    output logic [WRAP_W-1:0] wrapCount
);

    typedef enum logic [1:0] {
        SEEK   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]  BIN_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]  BIN_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]  BIN_MAX  = {WIDTH{1'b1}};
    localparam logic [ERR_W-1:0]  ERR_ZERO = {ERR_W{1'b0}};
    localparam logic [ERR_W-1:0]  ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0]  ERR_MAX  = {ERR_W{1'b1}};
    localparam logic [WRAP_W-1:0] WRAP_ZERO = {WRAP_W{1'b0}};
    localparam logic [WRAP_W-1:0] WRAP_ONE  = {{(WRAP_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]        ACQ_ZERO  = 4'd0;
    localparam logic [3:0]        LOCK_TGT  = 4'(LOCK_CNT);

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = {WIDTH{1'b0}};
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    state_t              state_r;
    logic [WIDTH-1:0]    prev_bin_r;
    logic [3:0]          acq_cnt_r;
    logic [WIDTH-1:0]    bin_out_r;
    logic                bin_valid_r;
    logic                locked_r;
    logic                err_pulse_r;
    logic [ERR_W-1:0]    err_count_r;
    logic [WRAP_W-1:0]   wrap_count_r;

    logic [WIDTH-1:0]    bin_s;
    logic [WIDTH-1:0]    succ_s;
    logic [3:0]          acq_next_s;
    logic                hold_s;
    logic                step_s;
    logic                illegal_s;
    logic                err_event_s;
    logic                wrap_event_s;

    // Decode the incoming word and classify it against the previous sample.
    always_comb begin
        bin_s      = gray_to_bin(grayIn);
        succ_s     = prev_bin_r + BIN_ONE;
        acq_next_s = acq_cnt_r + 4'd1;
        hold_s     = 1'b0;
        step_s     = 1'b0;
        illegal_s  = 1'b0;
        if (bin_s == prev_bin_r) begin
            hold_s = 1'b1;
        end else if (bin_s == succ_s) begin
            step_s = 1'b1;
        end else begin
            illegal_s = 1'b1;
        end
    end

    // Counter events: errors in ACQ/LOCKED, wraps only while already LOCKED.
    always_comb begin
        err_event_s  = 1'b0;
        wrap_event_s = 1'b0;
        if (sampleEn && (state_r != SEEK)) begin
            err_event_s  = illegal_s;
            wrap_event_s = (state_r == LOCKED) && step_s &&
                           (prev_bin_r == BIN_MAX) && (bin_s == BIN_ZERO);
        end else begin
            err_event_s  = 1'b0;
            wrap_event_s = 1'b0;
        end
    end

    // Lock FSM with registered decode, valid, lock and error-pulse outputs.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_r     <= SEEK;
            prev_bin_r  <= BIN_ZERO;
            acq_cnt_r   <= ACQ_ZERO;
            bin_out_r   <= BIN_ZERO;
            bin_valid_r <= 1'b0;
            locked_r    <= 1'b0;
            err_pulse_r <= 1'b0;
        end else if (sampleEn) begin
            bin_out_r   <= bin_s;
            bin_valid_r <= 1'b1;
            prev_bin_r  <= bin_s;
            err_pulse_r <= 1'b0;
            case (state_r)
                SEEK: begin
                    state_r   <= ACQ;
                    acq_cnt_r <= ACQ_ZERO;
                    locked_r  <= 1'b0;
                end
                ACQ: begin
                    if (step_s) begin
                        acq_cnt_r <= acq_next_s;
                        if (acq_next_s >= LOCK_TGT) begin
                            state_r  <= LOCKED;
                            locked_r <= 1'b1;
                        end else begin
                            locked_r <= 1'b0;
                        end
                    end else if (illegal_s) begin
                        acq_cnt_r   <= ACQ_ZERO;
                        err_pulse_r <= 1'b1;
                        locked_r    <= 1'b0;
                    end else begin
                        locked_r <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (illegal_s) begin
                        state_r     <= ACQ;
                        acq_cnt_r   <= ACQ_ZERO;
                        err_pulse_r <= 1'b1;
                        locked_r    <= 1'b0;
                    end else begin
                        locked_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= SEEK;
                    acq_cnt_r <= ACQ_ZERO;
                    locked_r  <= 1'b0;
                end
            endcase
        end else begin
            bin_valid_r <= 1'b0;
            err_pulse_r <= 1'b0;
        end
    end

    // Health counters; a synchronous clear overrides any concurrent increment.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            err_count_r  <= ERR_ZERO;
            wrap_count_r <= WRAP_ZERO;
        end else if (clrCounts) begin
            err_count_r  <= ERR_ZERO;
            wrap_count_r <= WRAP_ZERO;
        end else begin
            if (err_event_s && (err_count_r != ERR_MAX)) begin
                err_count_r <= err_count_r + ERR_ONE;
            end
            if (wrap_event_s) begin
                wrap_count_r <= wrap_count_r + WRAP_ONE;
            end
        end
    end

    assign binOut    = bin_out_r;
    assign binValid  = bin_valid_r;
    assign locked    = locked_r;
    assign errPulse  = err_pulse_r;
    assign errCount  = err_count_r;
    assign wrapCount = wrap_count_r;

    logic unused_s;
    assign unused_s = hold_s;

endmodule

// File: tb/tb_gray_seq_monitor.sv
// Scoreboard bench for gray_seq_monitor: stimulus pushes expected output words,
// a negedge monitor pops and compares them whenever binValid is presented.
module tb_gray_seq_monitor;

    logic       clk;
    logic       rstN;
    logic [2:0] grayIn;
    logic       sampleEn;
    logic       clrCounts;
    logic [2:0] binOut;
    logic       binValid;
    logic       locked;
    logic       errPulse;
    logic [7:0] errCount;
    logic [7:0] wrapCount;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [20:0] exp_q[$];
    logic [20:0] mon_exp;

    gray_seq_monitor #(.WIDTH(3), .LOCK_CNT(4), .ERR_W(8), .WRAP_W(8)) dut (
        .clk(clk), .rstN(rstN), .grayIn(grayIn), .sampleEn(sampleEn),
        .clrCounts(clrCounts), .binOut(binOut), .binValid(binValid),
        .locked(locked), .errPulse(errPulse), .errCount(errCount),
        .wrapCount(wrapCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed expectation word: {bin, locked, errPulse, errCount, wrapCount}.
    function automatic logic [20:0] pk(input int b, input logic lk, input logic ep,
                                       input int ec, input int wc);
        logic [2:0] bb;
        logic [7:0] e8;
        logic [7:0] w8;
        bb = b[2:0];
        e8 = ec[7:0];
        w8 = wc[7:0];
        return {bb, lk, ep, e8, w8};
    endfunction

    function automatic logic [2:0] gr(input int b);
        logic [2:0] bb;
        bb = b[2:0];
        return bb ^ (bb >> 1);
    endfunction

    function automatic logic [20:0] act_word();
        return {binOut, locked, errPulse, errCount, wrapCount};
    endfunction

    task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sample(input logic [2:0] g, input logic clr, input logic [20:0] exp);
        grayIn    = g;
        sampleEn  = 1'b1;
        clrCounts = clr;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        sampleEn  = 1'b0;
        clrCounts = 1'b0;
    endtask

    // Monitor: every presented result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (binValid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_valid: got %h with no expectation", act_word());
            end else begin
                mon_exp = exp_q.pop_front();
                check("sample_result", {1'b0, act_word()}, {1'b0, mon_exp});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        rstN = 1'b0; grayIn = 3'b000; sampleEn = 1'b0; clrCounts = 1'b0;
        #12;
        check("reset_state", {binValid, act_word()}, 22'd0);
        #10;
        rstN = 1'b1;
        @(posedge clk); #1;

        // Acquire: four legal steps after the SEEK capture.
        sample(3'b000, 1'b0, pk(0, 1'b0, 1'b0, 0, 0));
        sample(3'b001, 1'b0, pk(1, 1'b0, 1'b0, 0, 0));
        sample(3'b011, 1'b0, pk(2, 1'b0, 1'b0, 0, 0));
        sample(3'b010, 1'b0, pk(3, 1'b0, 1'b0, 0, 0));
        sample(3'b110, 1'b0, pk(4, 1'b1, 1'b0, 0, 0));

        // Locked run through wrap-arounds.
        sample(3'b111, 1'b0, pk(5, 1'b1, 1'b0, 0, 0));
        sample(3'b101, 1'b0, pk(6, 1'b1, 1'b0, 0, 0));
        sample(3'b100, 1'b0, pk(7, 1'b1, 1'b0, 0, 0));
        sample(3'b000, 1'b0, pk(0, 1'b1, 1'b0, 0, 1));
        for (int k = 1; k <= 16; k++) begin
            sample(gr(k % 8), 1'b0, pk(k % 8, 1'b1, 1'b0, 0, 1 + k / 8));
        end

        // Skip from 2 to 4 drops lock; the relock path crosses 7->0 in ACQ (no wrap count).
        sample(3'b001, 1'b0, pk(1, 1'b1, 1'b0, 0, 3));
        sample(3'b011, 1'b0, pk(2, 1'b1, 1'b0, 0, 3));
        sample(3'b110, 1'b0, pk(4, 1'b0, 1'b1, 1, 3));
        sample(3'b111, 1'b0, pk(5, 1'b0, 1'b0, 1, 3));
        sample(3'b101, 1'b0, pk(6, 1'b0, 1'b0, 1, 3));
        sample(3'b100, 1'b0, pk(7, 1'b0, 1'b0, 1, 3));
        sample(3'b000, 1'b0, pk(0, 1'b1, 1'b0, 1, 3));

        // Idle with a wandering input: everything holds, pulses stay low.
        for (int i = 0; i < 10; i++) begin
            r = $urandom_range(0, 7);
            grayIn = r[2:0];
            @(posedge clk);
            @(negedge clk);
            check("idle_hold", {binValid, act_word()}, {1'b0, pk(0, 1'b1, 1'b0, 1, 3)});
        end
        @(posedge clk); #1;
        sample(3'b000, 1'b0, pk(0, 1'b1, 1'b0, 1, 3));
        sample(3'b000, 1'b0, pk(0, 1'b1, 1'b0, 1, 3));

        // Saturate the error counter with alternating 0/4 samples.
        for (int k = 1; k <= 300; k++) begin
            sample((k % 2 == 1) ? 3'b110 : 3'b000, 1'b0,
                   pk((k % 2 == 1) ? 4 : 0, 1'b0, 1'b1, (1 + k > 255) ? 255 : 1 + k, 3));
        end
        sample(3'b110, 1'b1, pk(4, 1'b0, 1'b1, 0, 0));

        // Mid-stream asynchronous reset between clock edges.
        sample(3'b111, 1'b0, pk(5, 1'b0, 1'b0, 0, 0));
        sample(3'b010, 1'b0, pk(3, 1'b0, 1'b1, 1, 0));
        @(negedge clk); #2;
        rstN = 1'b0;
        #1;
        check("async_reset", {binValid, act_word()}, 22'd0);
        #3;
        rstN = 1'b1;
        @(posedge clk); #1;
        sample(3'b101, 1'b0, pk(6, 1'b0, 1'b0, 0, 0));
        sample(3'b100, 1'b0, pk(7, 1'b0, 1'b0, 0, 0));
        sample(3'b110, 1'b0, pk(4, 1'b0, 1'b1, 1, 0));

        @(negedge clk); #1;
        check("queue_drained", {19'd0, exp_q.size() != 0, 2'b00}, 22'd0);
        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
